// File: rtl/wb_rr_arbiter_if.sv
// ---------------------------------------------------------------------------
// wb_arb_if
// Classic-cycle Wishbone bus bundle used on every arbiter port.
//
// Signals (named from the master's point of view):
//   cyc, stb, we   bus cycle, strobe, write enable        (master -> slave)
//   adr            address, ADR_WIDTH                     (master -> slave)
//   dat_w          write data, DAT_WIDTH                  (master -> slave)
//   dat_r          read data, DAT_WIDTH                   (slave -> master)
//   ack, err       cycle termination                      (slave -> master)
//
// Modports:
//   master  the side that starts cycles (CPU port, or the arbiter's slave port)
//   slave   the side that answers cycles (slave device, or the arbiter's
//           master-facing ports)
// ---------------------------------------------------------------------------
interface wb_arb_if #(
    parameter int DAT_WIDTH = 64,
    parameter int ADR_WIDTH = 16
);
    logic                 cyc;
    logic                 stb;
    logic                 we;
    logic [ADR_WIDTH-1:0] adr;
    logic [DAT_WIDTH-1:0] dat_w;
    logic [DAT_WIDTH-1:0] dat_r;
    logic                 ack;
    logic                 err;

    modport master (
        output cyc, stb, we, adr, dat_w,
        input  dat_r, ack, err
    );

    modport slave (
        input  cyc, stb, we, adr, dat_w,
        output dat_r, ack, err
    );
endinterface

// File: rtl/wb_rr_arbiter.sv
// ---------------------------------------------------------------------------
// wb_rr_arbiter
// Two-master round-robin arbiter in front of one classic-cycle Wishbone slave.
// Master 0 is the instruction fetch port, master 1 the data port. Ownership is
// held for the whole bus cycle (cyc); the slave's ack/err/dat reach only the
// owner. One idle cycle always separates two owners.
//
// Ports:
//   clk_i    system clock
//   rst_i    asynchronous reset, active low
//   m0_if    master 0 bus (slave modport: arbiter answers master 0)
//   m1_if    master 1 bus (slave modport: arbiter answers master 1)
//   s_if     shared slave bus (master modport: arbiter drives the slave)
//   gnt_o    one-hot current owner, 00 when idle (debug)
//
// Build option:
//   WB_ARB_TIMEOUT_EN  when defined, a watchdog ends any strobe left
//                      unanswered for TIMEOUT cycles by raising err to the
//                      owner and withdrawing stb from the slave. When not
//                      defined, a hung slave holds the bus indefinitely.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no owner; slave side and both master responses held at 0
// GNT0  | master 0 owns the slave port until m0 cyc drops
// GNT1  | master 1 owns the slave port until m1 cyc drops
// ---------------------------------------------------------------------------
module wb_rr_arbiter #(
    parameter int DAT_WIDTH = 64,
    parameter int ADR_WIDTH = 16,
    parameter int TIMEOUT   = 255
) (
    input  logic       clk_i,
    input  logic       rst_i,
    wb_arb_if.slave    m0_if,
    wb_arb_if.slave    m1_if,
    wb_arb_if.master   s_if,
    output logic [1:0] gnt_o
);

    if (TIMEOUT < 2) begin : g_timeout_check
        $error("wb_rr_arbiter: TIMEOUT must be at least 2");
    end

    // Encoding chosen so that the grant states read directly as one-hot.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        GNT0 = 2'b01,
        GNT1 = 2'b10
    } state_t;

    state_t state_q, state_d;
    logic   last_q, last_d;

    logic                 own_cyc;
    logic                 own_stb;
    logic                 own_we;
    logic [ADR_WIDTH-1:0] own_adr;
    logic [DAT_WIDTH-1:0] own_dat;
    logic                 to_err;
    logic                 sel0;
    logic                 sel1;

    // -----------------------------------------------------------------------
    // State register. last resets to 1 so master 0 wins the first tie.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (m0_if.cyc && m1_if.cyc) begin
                    if (last_q) begin
                        state_d = GNT0;
                        last_d  = 1'b0;
                    end else begin
                        state_d = GNT1;
                        last_d  = 1'b1;
                    end
                end else if (m0_if.cyc) begin
                    state_d = GNT0;
                    last_d  = 1'b0;
                end else if (m1_if.cyc) begin
                    state_d = GNT1;
                    last_d  = 1'b1;
                end
            end
            GNT0: begin
                if (!m0_if.cyc) begin
                    state_d = IDLE;
                end
            end
            GNT1: begin
                if (!m1_if.cyc) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Owner request mux; everything is zero while idle.
    // -----------------------------------------------------------------------
    always_comb begin
        own_cyc = 1'b0;
        own_stb = 1'b0;
        own_we  = 1'b0;
        own_adr = '0;
        own_dat = '0;
        case (state_q)
            GNT0: begin
                own_cyc = m0_if.cyc;
                own_stb = m0_if.stb;
                own_we  = m0_if.we;
                own_adr = m0_if.adr;
                own_dat = m0_if.dat_w;
            end
            GNT1: begin
                own_cyc = m1_if.cyc;
                own_stb = m1_if.stb;
                own_we  = m1_if.we;
                own_adr = m1_if.adr;
                own_dat = m1_if.dat_w;
            end
            default: begin
            end
        endcase
    end

`ifdef WB_ARB_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             to_err_q, to_err_d;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt_q    <= '0;
            to_err_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            to_err_q <= to_err_d;
        end
    end

    // The counter only runs while a strobe is actually presented to the
    // slave and unanswered. Once the flag is up, stb is withdrawn, so the
    // counter falls back to zero by itself; the flag then waits for the
    // owner to end the strobe or the cycle.
    always_comb begin
        cnt_d    = '0;
        to_err_d = to_err_q;
        if (s_if.stb && !(s_if.ack || s_if.err)) begin
            if (cnt_q != CNT_W'(TIMEOUT - 1)) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        if (!own_stb || !own_cyc) begin
            to_err_d = 1'b0;
        end else if (s_if.stb && !(s_if.ack || s_if.err) &&
                     (cnt_q == CNT_W'(TIMEOUT - 1))) begin
            to_err_d = 1'b1;
        end
    end

    assign to_err = to_err_q;
`else
    assign to_err = 1'b0;
`endif

    // -----------------------------------------------------------------------
    // Slave-side drive and owner-only response routing.
    // -----------------------------------------------------------------------
    assign sel0 = (state_q == GNT0);
    assign sel1 = (state_q == GNT1);

    assign s_if.cyc   = own_cyc;
    assign s_if.stb   = own_stb & ~to_err;
    assign s_if.we    = own_we;
    assign s_if.adr   = own_adr;
    assign s_if.dat_w = own_dat;

    assign m0_if.ack   = sel0 & s_if.ack;
    assign m0_if.err   = sel0 & (s_if.err | to_err);
    assign m0_if.dat_r = sel0 ? s_if.dat_r : '0;

    assign m1_if.ack   = sel1 & s_if.ack;
    assign m1_if.err   = sel1 & (s_if.err | to_err);
    assign m1_if.dat_r = sel1 ? s_if.dat_r : '0;

    assign gnt_o = {sel1, sel0};

endmodule

// File: tb/tb_wb_rr_arbiter.sv
module tb_wb_rr_arbiter;
    localparam int DW = 64;
    localparam int AW = 16;
    localparam int TO = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic [1:0] gnt;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    wb_arb_if #(.DAT_WIDTH(DW), .ADR_WIDTH(AW)) m0_bus ();
    wb_arb_if #(.DAT_WIDTH(DW), .ADR_WIDTH(AW)) m1_bus ();
    wb_arb_if #(.DAT_WIDTH(DW), .ADR_WIDTH(AW)) s_bus ();

    wb_rr_arbiter #(.DAT_WIDTH(DW), .ADR_WIDTH(AW), .TIMEOUT(TO)) dut (
        .clk_i (clk),
        .rst_i (rst_n),
        .m0_if (m0_bus),
        .m1_if (m1_bus),
        .s_if  (s_bus),
        .gnt_o (gnt)
    );

    function automatic logic [DW-1:0] rom_word(input logic [AW-1:0] a);
        return 64'h0204000000200420 ^ {a, a, a, a};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_m(input int i, input logic c, input logic s, input logic w,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (i == 0) begin
            m0_bus.cyc = c; m0_bus.stb = s; m0_bus.we = w; m0_bus.adr = a; m0_bus.dat_w = d;
        end else begin
            m1_bus.cyc = c; m1_bus.stb = s; m1_bus.we = w; m1_bus.adr = a; m1_bus.dat_w = d;
        end
    endtask

    task automatic drive_idle();
        set_m(0, 1'b0, 1'b0, 1'b0, '0, '0);
        set_m(1, 1'b0, 1'b0, 1'b0, '0, '0);
        s_bus.ack = 1'b0; s_bus.err = 1'b0; s_bus.dat_r = '0;
    endtask

    task automatic do_reset();
        drive_idle();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // -----------------------------------------------------------------------
    task automatic test_reset();
        drive_idle();
        rst_n = 1'b0;
        set_m(0, 1'b1, 1'b1, 1'b0, '0, '0);
        s_bus.ack = 1'b1; s_bus.dat_r = '1;
        #1;
        n_checks++; if (gnt !== 2'b00) $display("FAIL reset_gnt: got %b want 00", gnt); else n_pass++;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (gnt !== 2'b00) $display("FAIL reset_gnt_held: got %b want 00", gnt); else n_pass++;
        n_checks++; if ({s_bus.cyc, s_bus.stb} !== 2'b00) $display("FAIL reset_s_cyc_stb: got %b want 00", {s_bus.cyc, s_bus.stb}); else n_pass++;
        n_checks++; if ({m0_bus.ack, m0_bus.err, m0_bus.dat_r} !== '0) $display("FAIL reset_m0_resp: got %h want 0", {m0_bus.ack, m0_bus.err, m0_bus.dat_r}); else n_pass++;
        drive_idle();
        rst_n = 1'b1;
    endtask

    task automatic test_single_read();
        do_reset();
        set_m(0, 1'b1, 1'b1, 1'b0, 16'h0000, '0);
        #1;
        n_checks++; if (gnt !== 2'b00 || s_bus.cyc !== 1'b0) $display("FAIL single_pre_grant: gnt %b s_cyc %b want 00/0", gnt, s_bus.cyc); else n_pass++;
        tick();
        n_checks++; if (gnt !== 2'b01) $display("FAIL single_gnt: got %b want 01", gnt); else n_pass++;
        n_checks++; if ({s_bus.cyc, s_bus.stb, s_bus.adr} !== {2'b11, 16'h0000}) $display("FAIL single_s_side: got %h want 30000", {s_bus.cyc, s_bus.stb, s_bus.adr}); else n_pass++;
        n_checks++; if (m0_bus.ack !== 1'b0) $display("FAIL single_early_ack: got %b want 0", m0_bus.ack); else n_pass++;
        tick();
        s_bus.ack = 1'b1; s_bus.dat_r = rom_word(s_bus.adr);
        #1;
        n_checks++; if ({m0_bus.ack, m0_bus.err} !== 2'b10) $display("FAIL single_ack: got %b want 10", {m0_bus.ack, m0_bus.err}); else n_pass++;
        n_checks++; if (m0_bus.dat_r !== 64'h0204000000200420) $display("FAIL single_dat: got %h want 0204000000200420", m0_bus.dat_r); else n_pass++;
        n_checks++; if ({m1_bus.ack, m1_bus.err, m1_bus.dat_r} !== '0) $display("FAIL single_m1_quiet: got %h want 0", {m1_bus.ack, m1_bus.err, m1_bus.dat_r}); else n_pass++;
        tick();
        drive_idle();
        #1;
        n_checks++; if (gnt !== 2'b01 || s_bus.cyc !== 1'b0) $display("FAIL single_release_cycle: gnt %b s_cyc %b want 01/0", gnt, s_bus.cyc); else n_pass++;
        tick();
        n_checks++; if (gnt !== 2'b00) $display("FAIL single_idle_after: got %b want 00", gnt); else n_pass++;
    endtask

    task automatic test_alternate();
        int   seq[$];
        int   gaps[$];
        int   rem[2];
        bit   acked[2];
        bit   dropped[2];
        bit   arm;
        bit   done;
        int   idle_run;
        logic [1:0] g, prev_g;
        do_reset();
        rem = '{4, 4}; acked = '{0, 0}; dropped = '{1, 1};
        arm = 0; done = 0; idle_run = 0; prev_g = 2'b00;
        for (int c = 0; c < 200; c++) begin
            for (int i = 0; i < 2; i++) begin
                if (acked[i]) begin
                    set_m(i, 1'b0, 1'b0, 1'b0, '0, '0);
                    rem[i]--; acked[i] = 0; dropped[i] = 1;
                end else if (dropped[i] && rem[i] > 0) begin
                    set_m(i, 1'b1, 1'b1, 1'b0, AW'(16'h0100 * (i + 1) + rem[i]), '0);
                    dropped[i] = 0;
                end
            end
            #1;
            s_bus.ack   = arm && s_bus.stb;
            s_bus.dat_r = s_bus.ack ? rom_word(s_bus.adr) : '0;
            #1;
            g = gnt;
            if (g == 2'b00) begin
                idle_run++;
            end else begin
                if (prev_g == 2'b00) begin
                    seq.push_back((g == 2'b01) ? 0 : 1);
                    gaps.push_back(idle_run);
                end
                idle_run = 0;
                n_checks++;
                if (((g == 2'b01) ? m1_bus.ack : m0_bus.ack) !== 1'b0)
                    $display("FAIL alt_nonowner_ack: gnt %b m0_ack %b m1_ack %b want nonowner 0", g, m0_bus.ack, m1_bus.ack);
                else n_pass++;
            end
            acked[0] = m0_bus.ack;
            acked[1] = m1_bus.ack;
            arm      = s_bus.stb && !s_bus.ack;
            prev_g   = g;
            if (rem[0] == 0 && rem[1] == 0 && g == 2'b00) begin
                done = 1;
                break;
            end
            tick();
        end
        n_checks++; if (!done) $display("FAIL alt_timeout: remaining %0d/%0d want 0/0", rem[0], rem[1]); else n_pass++;
        n_checks++; if (seq.size() != 8) $display("FAIL alt_grant_count: got %0d want 8", seq.size()); else n_pass++;
        for (int k = 0; k < seq.size(); k++) begin
            n_checks++; if (seq[k] != (k % 2)) $display("FAIL alt_order[%0d]: got m%0d want m%0d", k, seq[k], k % 2); else n_pass++;
            n_checks++; if (gaps[k] != 1) $display("FAIL alt_gap[%0d]: got %0d idle cycles want 1", k, gaps[k]); else n_pass++;
        end
        drive_idle();
        tick();
    endtask

    task automatic test_wait();
        do_reset();
        set_m(1, 1'b1, 1'b1, 1'b0, AW'($urandom), '0);
        tick();
        n_checks++; if (gnt !== 2'b10) $display("FAIL wait_m1_gnt: got %b want 10", gnt); else n_pass++;
        for (int k = 0; k < 3; k++) begin
            if (k == 0) set_m(0, 1'b1, 1'b1, 1'b0, 16'h0040, '0);
            s_bus.ack   = (k == 2);
            s_bus.dat_r = rom_word(s_bus.adr);
            #1;
            n_checks++; if ({gnt, m0_bus.ack, m0_bus.dat_r} !== {2'b10, 1'b0, 64'h0}) $display("FAIL wait_m0_blocked[%0d]: gnt %b m0_ack %b m0_dat %h want 10/0/0", k, gnt, m0_bus.ack, m0_bus.dat_r); else n_pass++;
            if (k == 2) begin
                n_checks++; if (m1_bus.ack !== 1'b1) $display("FAIL wait_m1_ack: got %b want 1", m1_bus.ack); else n_pass++;
            end
            tick();
        end
        set_m(1, 1'b0, 1'b0, 1'b0, '0, '0);
        s_bus.ack = 1'b0;
        #1;
        n_checks++; if (gnt !== 2'b10) $display("FAIL wait_release_cycle: got %b want 10", gnt); else n_pass++;
        tick();
        n_checks++; if (gnt !== 2'b00 || m0_bus.ack !== 1'b0) $display("FAIL wait_idle_gap: gnt %b m0_ack %b want 00/0", gnt, m0_bus.ack); else n_pass++;
        tick();
        n_checks++; if (gnt !== 2'b01) $display("FAIL wait_m0_gnt: got %b want 01", gnt); else n_pass++;
        s_bus.ack = 1'b1; s_bus.dat_r = rom_word(s_bus.adr);
        #1;
        n_checks++; if ({m0_bus.ack, m0_bus.dat_r} !== {1'b1, rom_word(16'h0040)}) $display("FAIL wait_m0_ack: got %h want %h", {m0_bus.ack, m0_bus.dat_r}, {1'b1, rom_word(16'h0040)}); else n_pass++;
        tick();
        drive_idle();
        tick();
    endtask

    task automatic test_err();
        logic [DW-1:0] d;
        d = {$urandom, $urandom};
        do_reset();
        set_m(1, 1'b1, 1'b1, 1'b1, 16'h0018, d);
        tick();
        n_checks++; if ({gnt, s_bus.we, s_bus.adr, s_bus.dat_w} !== {2'b10, 1'b1, 16'h0018, d}) $display("FAIL err_s_side: got %h want %h", {gnt, s_bus.we, s_bus.adr, s_bus.dat_w}, {2'b10, 1'b1, 16'h0018, d}); else n_pass++;
        tick();
        s_bus.err = 1'b1;
        #1;
        n_checks++; if ({m1_bus.err, m1_bus.ack} !== 2'b10) $display("FAIL err_m1: err/ack got %b want 10", {m1_bus.err, m1_bus.ack}); else n_pass++;
        n_checks++; if ({m0_bus.err, m0_bus.ack} !== 2'b00) $display("FAIL err_m0_quiet: got %b want 00", {m0_bus.err, m0_bus.ack}); else n_pass++;
        tick();
        s_bus.err = 1'b0;
        set_m(1, 1'b1, 1'b0, 1'b1, 16'h0018, d);
        for (int k = 0; k < 3; k++) begin
            tick();
            n_checks++; if (gnt !== 2'b10) $display("FAIL err_hold[%0d]: got %b want 10", k, gnt); else n_pass++;
        end
        set_m(1, 1'b0, 1'b0, 1'b0, '0, '0);
        tick();
        n_checks++; if (gnt !== 2'b00) $display("FAIL err_release: got %b want 00", gnt); else n_pass++;
    endtask

    task automatic test_timeout();
        do_reset();
        set_m(0, 1'b1, 1'b1, 1'b0, 16'h0100, '0);
        tick();
        for (int k = 1; k <= 4; k++) begin
            n_checks++; if ({m0_bus.err, s_bus.stb} !== 2'b01) $display("FAIL to_wait[%0d]: err/stb got %b want 01", k, {m0_bus.err, s_bus.stb}); else n_pass++;
            tick();
        end
`ifdef WB_ARB_TIMEOUT_EN
        n_checks++; if ({m0_bus.err, m0_bus.ack, s_bus.stb} !== 3'b100) $display("FAIL to_fire: err/ack/stb got %b want 100", {m0_bus.err, m0_bus.ack, s_bus.stb}); else n_pass++;
        tick();
        set_m(0, 1'b1, 1'b0, 1'b0, 16'h0100, '0);
        tick();
        n_checks++; if (m0_bus.err !== 1'b0) $display("FAIL to_clear: err got %b want 0", m0_bus.err); else n_pass++;
`else
        for (int k = 5; k <= 100; k++) begin
            n_checks++; if ({m0_bus.err, s_bus.stb} !== 2'b01) $display("FAIL to_off_hang[%0d]: err/stb got %b want 01", k, {m0_bus.err, s_bus.stb}); else n_pass++;
            tick();
        end
`endif
        drive_idle();
        tick();
        tick();
    endtask

    task automatic test_reset_mid();
        do_reset();
        set_m(0, 1'b1, 1'b1, 1'b0, 16'h0000, '0);
        tick();
        n_checks++; if (gnt !== 2'b01) $display("FAIL rmid_pre: got %b want 01", gnt); else n_pass++;
        s_bus.ack = 1'b1; s_bus.dat_r = rom_word(16'h0000);
        rst_n = 1'b0;
        #1;
        n_checks++; if ({gnt, s_bus.cyc, s_bus.stb} !== 4'b0000) $display("FAIL rmid_drop: gnt/cyc/stb got %b want 0000", {gnt, s_bus.cyc, s_bus.stb}); else n_pass++;
        n_checks++; if ({m0_bus.ack, m0_bus.dat_r} !== '0) $display("FAIL rmid_no_ack: got %h want 0", {m0_bus.ack, m0_bus.dat_r}); else n_pass++;
        tick();
        s_bus.ack = 1'b0; s_bus.dat_r = '0;
        rst_n = 1'b1;
        set_m(1, 1'b1, 1'b1, 1'b0, 16'h0200, '0);
        #1;
        n_checks++; if (gnt !== 2'b00) $display("FAIL rmid_idle: got %b want 00", gnt); else n_pass++;
        tick();
        n_checks++; if (gnt !== 2'b01) $display("FAIL rmid_first_tie: got %b want 01", gnt); else n_pass++;
        drive_idle();
        tick();
        tick();
    endtask

    // Random traffic from both masters against a slave answering within
    // three strobed cycles; expected outputs come from the ownership rules.
    logic          r_cyc[2], r_stb[2], r_we[2];
    logic [AW-1:0] r_adr[2];
    logic [DW-1:0] r_dat[2];

    task automatic new_strobe(input int i);
        r_stb[i] = 1'b1;
        r_we[i]  = 1'($urandom_range(0, 1));
        r_adr[i] = AW'($urandom);
        r_dat[i] = {$urandom, $urandom};
    endtask

    task automatic test_random();
        int   owner, last;
        bit   seen[2];
        logic pcyc[2];
        int   wcnt, wtgt;
        logic [2+AW+DW:0] exp_s, got_s;
        logic [DW+1:0]    exp_m0, exp_m1, got_m0, got_m1;
        logic [1:0]       exp_g;
        do_reset();
        owner = -1; last = 1; wcnt = 0; wtgt = 0;
        for (int i = 0; i < 2; i++) begin
            r_cyc[i] = 0; r_stb[i] = 0; r_we[i] = 0; r_adr[i] = '0; r_dat[i] = '0;
            seen[i] = 0; pcyc[i] = 0;
        end
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < 2; i++) begin
                if (!r_cyc[i]) begin
                    if ($urandom_range(0, 3) == 0) begin r_cyc[i] = 1'b1; new_strobe(i); end
                end else if (seen[i]) begin
                    case ($urandom_range(0, 2))
                        0: begin r_cyc[i] = 1'b0; r_stb[i] = 1'b0; end
                        1: r_stb[i] = 1'b0;
                        default: new_strobe(i);
                    endcase
                end else if (!r_stb[i]) begin
                    if ($urandom_range(0, 1) == 1) new_strobe(i);
                    else r_cyc[i] = 1'b0;
                end
                set_m(i, r_cyc[i], r_stb[i], r_we[i], r_adr[i], r_dat[i]);
            end
            #1;
            s_bus.dat_r = {$urandom, $urandom};
            if (s_bus.stb) begin
                if (wcnt >= wtgt) begin
                    s_bus.err = ($urandom_range(0, 7) == 0);
                    s_bus.ack = !s_bus.err;
                    wcnt = 0; wtgt = $urandom_range(0, 2);
                end else begin
                    s_bus.ack = 1'b0; s_bus.err = 1'b0; wcnt++;
                end
            end else begin
                s_bus.ack = 1'b0; s_bus.err = 1'b0; wcnt = 0;
            end
            #1;
            exp_g  = (owner < 0) ? 2'b00 : ((owner == 0) ? 2'b01 : 2'b10);
            exp_s  = (owner < 0) ? '0 : {r_cyc[owner], r_stb[owner], r_we[owner], r_adr[owner], r_dat[owner]};
            exp_m0 = (owner == 0) ? {s_bus.ack, s_bus.err, s_bus.dat_r} : '0;
            exp_m1 = (owner == 1) ? {s_bus.ack, s_bus.err, s_bus.dat_r} : '0;
            got_s  = {s_bus.cyc, s_bus.stb, s_bus.we, s_bus.adr, s_bus.dat_w};
            got_m0 = {m0_bus.ack, m0_bus.err, m0_bus.dat_r};
            got_m1 = {m1_bus.ack, m1_bus.err, m1_bus.dat_r};
            n_checks++; if (gnt !== exp_g) $display("FAIL rnd_gnt@%0d: got %b want %b", c, gnt, exp_g); else n_pass++;
            n_checks++; if (got_s !== exp_s) $display("FAIL rnd_slave@%0d: got %h want %h", c, got_s, exp_s); else n_pass++;
            n_checks++; if (got_m0 !== exp_m0) $display("FAIL rnd_m0@%0d: got %h want %h", c, got_m0, exp_m0); else n_pass++;
            n_checks++; if (got_m1 !== exp_m1) $display("FAIL rnd_m1@%0d: got %h want %h", c, got_m1, exp_m1); else n_pass++;
            seen[0] = r_stb[0] && (m0_bus.ack || m0_bus.err);
            seen[1] = r_stb[1] && (m1_bus.ack || m1_bus.err);
            pcyc[0] = r_cyc[0];
            pcyc[1] = r_cyc[1];
            tick();
            if (owner < 0) begin
                if (pcyc[0] && pcyc[1]) owner = (last == 0) ? 1 : 0;
                else if (pcyc[0])       owner = 0;
                else if (pcyc[1])       owner = 1;
                if (owner >= 0) last = owner;
            end else if (!pcyc[owner]) begin
                owner = -1;
            end
        end
        drive_idle();
        tick();
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_read();
        test_alternate();
        test_wait();
        test_err();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
